operand_fetch_stage: RTL

OPERAND_FETCH_STAGE -- requirements
Module: operand_fetch_stage

---
 rtl/of_pkg.sv | 86 ++++++++
 rtl/of_fwd_mux.sv | 48 ++++
 rtl/operand_fetch_stage.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/of_pkg.sv
// Shared decode constants, FSM state type and instruction-field helpers for the
// operand fetch stage.
package of_pkg;

  localparam int XLEN = 32;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_MUL  = 5'd2;
  localparam logic [4:0] OP_DIV  = 5'd3;
  localparam logic [4:0] OP_MOD  = 5'd4;
  localparam logic [4:0] OP_CMP  = 5'd5;
  localparam logic [4:0] OP_AND  = 5'd6;
  localparam logic [4:0] OP_OR   = 5'd7;
  localparam logic [4:0] OP_NOT  = 5'd8;
  localparam logic [4:0] OP_MOV  = 5'd9;
  localparam logic [4:0] OP_LSL  = 5'd10;
  localparam logic [4:0] OP_LSR  = 5'd11;
  localparam logic [4:0] OP_ASR  = 5'd12;
  localparam logic [4:0] OP_NOP  = 5'd13;
  localparam logic [4:0] OP_LD   = 5'd14;
  localparam logic [4:0] OP_ST   = 5'd15;
  localparam logic [4:0] OP_BEQ  = 5'd16;
  localparam logic [4:0] OP_BGT  = 5'd17;
  localparam logic [4:0] OP_B    = 5'd18;
  localparam logic [4:0] OP_CALL = 5'd19;
  localparam logic [4:0] OP_RET  = 5'd20;

  localparam logic [1:0] MOD_SEXT     = 2'b00;
  localparam logic [1:0] MOD_ZEXT     = 2'b01;
  localparam logic [1:0] MOD_HIGH     = 2'b10;
  localparam logic [1:0] MOD_SEXT_ALT = 2'b11;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } of_state_e;

  typedef struct packed {
    logic [4:0]  opcode;
    logic        imm;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [1:0]  modifier;
    logic [15:0] imm16;
    logic [26:0] br_off;
  } inst_fields_t;

  function automatic inst_fields_t decode(input logic [31:0] inst);
    inst_fields_t f;
    f.opcode   = inst[31:27];
    f.imm      = inst[26];
    f.rd       = inst[25:22];
    f.rs1      = inst[21:18];
    f.rs2      = inst[17:14];
    f.modifier = inst[17:16];
    f.imm16    = inst[15:0];
    f.br_off   = inst[26:0];
    return f;
  endfunction

  function automatic logic uses_rs1(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_CMP, OP_AND, OP_OR,
      OP_LSL, OP_LSR, OP_ASR, OP_LD, OP_ST, OP_RET: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

  // Store reads its data register through the second port.
  function automatic logic uses_rs2(input logic [4:0] op, input logic imm);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_CMP, OP_AND, OP_OR,
      OP_NOT, OP_MOV, OP_LSL, OP_LSR, OP_ASR:         return !imm;
      OP_ST:                                          return 1'b1;
      OP_NOP, OP_LD, OP_BEQ, OP_BGT, OP_B, OP_CALL:   return 1'b0;
      default:                                        return 1'b0;
    endcase
  endfunction

  function automatic logic is_branch(input logic [4:0] op);
    return (op == OP_BEQ) || (op == OP_BGT) || (op == OP_B) || (op == OP_CALL);
  endfunction

endpackage

// File: rtl/of_fwd_mux.sv
// One-operand bypass selector plus the "source not ready" flag for that operand.
// Build option OF_FORWARD_EN: bypass EX/MA/RW results; otherwise read the register file only.
module of_fwd_mux #(
  parameter int XLEN = 32
) (
  input  logic [3:0]      src_idx,
  input  logic [XLEN-1:0] rf_data,
  input  logic            ex_wb_en,
  input  logic [3:0]      ex_wb_rd,
  input  logic            ex_is_ld,
  input  logic [XLEN-1:0] ex_data,
  input  logic            ma_wb_en,
  input  logic [3:0]      ma_wb_rd,
  input  logic [XLEN-1:0] ma_data,
  input  logic            rw_wb_en,
  input  logic [3:0]      rw_wb_rd,
  input  logic [XLEN-1:0] rw_data,
  output logic [XLEN-1:0] op_data,
  output logic            busy
);

  logic ex_hit;
  logic ma_hit;
  logic rw_hit;

  assign ex_hit = ex_wb_en && (ex_wb_rd == src_idx);
  assign ma_hit = ma_wb_en && (ma_wb_rd == src_idx);
  assign rw_hit = rw_wb_en && (rw_wb_rd == src_idx);

`ifdef OF_FORWARD_EN
  // Youngest producer wins; a load in EX has no data yet and only raises busy.
  always_comb begin
    op_data = rf_data;
    if (ex_hit && !ex_is_ld) op_data = ex_data;
    else if (ma_hit)         op_data = ma_data;
    else if (rw_hit)         op_data = rw_data;
  end

  assign busy = ex_hit && ex_is_ld;
`else
  assign op_data = rf_data;
  assign busy    = ex_hit || ma_hit || rw_hit;

  logic unused_fwd;
  assign unused_fwd = ^{ex_is_ld, ex_data, ma_data, rw_data};
`endif

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: decode, register read with bypass, hazard interlock and OF/EX latch.
// Build option OF_FORWARD_EN selects bypassing with load-use stall; default is full interlock.
module operand_fetch_stage
  import of_pkg::*;
#(
  parameter int XLEN   = of_pkg::XLEN,
  parameter int RA_IDX = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [31:0]     if_inst,
  input  logic [31:0]     if_pc,
  input  logic            flush,
  output logic            stall_out,
  output logic [3:0]      rs1_addr,
  output logic [3:0]      rs2_addr,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2,
  input  logic            ex_wb_en,
  input  logic [3:0]      ex_wb_rd,
  input  logic            ex_is_ld,
  input  logic [XLEN-1:0] ex_data,
  input  logic            ma_wb_en,
  input  logic [3:0]      ma_wb_rd,
  input  logic [XLEN-1:0] ma_data,
  input  logic            rw_wb_en,
  input  logic [3:0]      rw_wb_rd,
  input  logic [XLEN-1:0] rw_data,
  output logic            of_valid,
  output logic [31:0]     of_pc,
  output logic [31:0]     of_inst,
  output logic [XLEN-1:0] of_op1,
  output logic [XLEN-1:0] of_op2,
  output logic [XLEN-1:0] of_immx
);

  inst_fields_t    f;
  logic            use_rs1;
  logic            use_rs2;
  logic [XLEN-1:0] op1_fwd;
  logic [XLEN-1:0] op2_fwd;
  logic            busy1;
  logic            busy2;
  logic            hazard;
  logic            stall_raw;
  logic [XLEN-1:0] immx;

  of_state_e       state_q, state_d;
  logic            of_valid_q, of_valid_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  logic [XLEN-1:0] op1_q, op1_d;
  logic [XLEN-1:0] op2_q, op2_d;
  logic [XLEN-1:0] immx_q, immx_d;

  assign f       = decode(if_inst);
  assign use_rs1 = uses_rs1(f.opcode);
  assign use_rs2 = uses_rs2(f.opcode, f.imm);

  assign rs1_addr = (f.opcode == OP_RET) ? 4'(RA_IDX) : f.rs1;
  assign rs2_addr = (f.opcode == OP_ST)  ? f.rd       : f.rs2;

  always_comb begin
    immx = '0;
    if (is_branch(f.opcode)) begin
      immx = {{(XLEN-27){f.br_off[26]}}, f.br_off};
    end else begin
      case (f.modifier)
        MOD_ZEXT:               immx = {{(XLEN-16){1'b0}}, f.imm16};
        MOD_HIGH:               immx = XLEN'({f.imm16, 16'h0000});
        MOD_SEXT, MOD_SEXT_ALT: immx = {{(XLEN-16){f.imm16[15]}}, f.imm16};
        default:                immx = {{(XLEN-16){f.imm16[15]}}, f.imm16};
      endcase
    end
  end

  of_fwd_mux #(.XLEN(XLEN)) u_fwd_op1 (
    .src_idx (rs1_addr),
    .rf_data (rf_rd1),
    .ex_wb_en(ex_wb_en),
    .ex_wb_rd(ex_wb_rd),
    .ex_is_ld(ex_is_ld),
    .ex_data (ex_data),
    .ma_wb_en(ma_wb_en),
    .ma_wb_rd(ma_wb_rd),
    .ma_data (ma_data),
    .rw_wb_en(rw_wb_en),
    .rw_wb_rd(rw_wb_rd),
    .rw_data (rw_data),
    .op_data (op1_fwd),
    .busy    (busy1)
  );

  of_fwd_mux #(.XLEN(XLEN)) u_fwd_op2 (
    .src_idx (rs2_addr),
    .rf_data (rf_rd2),
    .ex_wb_en(ex_wb_en),
    .ex_wb_rd(ex_wb_rd),
    .ex_is_ld(ex_is_ld),
    .ex_data (ex_data),
    .ma_wb_en(ma_wb_en),
    .ma_wb_rd(ma_wb_rd),
    .ma_data (ma_data),
    .rw_wb_en(rw_wb_en),
    .rw_wb_rd(rw_wb_rd),
    .rw_data (rw_data),
    .op_data (op2_fwd),
    .busy    (busy2)
  );

  assign hazard = if_valid && ((use_rs1 && busy1) || (use_rs2 && busy2));

  // A flush kills the waiting instruction, so it also ends any stall at once.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    state_d   = state_q;
    stall_raw = 1'b0;
    if (flush) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (hazard) begin
            state_d   = STALL;
            stall_raw = 1'b1;
          end
        end
        STALL: begin
          if (hazard) stall_raw = 1'b1;
          else        state_d   = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign stall_out = stall_raw && !rst;

  always_comb begin
    of_valid_d = 1'b0;
    pc_d       = pc_q;
    inst_d     = inst_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    immx_d     = immx_q;
    if (!flush && !stall_raw) begin
      of_valid_d = if_valid;
      pc_d       = if_pc;
      inst_d     = if_inst;
      op1_d      = op1_fwd;
      op2_d      = op2_fwd;
      immx_d     = immx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: data fields are reset along with valid so a reset latch never shows stale operands.
      state_q    <= RUN;
      of_valid_q <= 1'b0;
      pc_q       <= '0;
      inst_q     <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      immx_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register sample the same pre-edge values.
      state_q    <= state_d;
      of_valid_q <= of_valid_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      immx_q     <= immx_d;
    end
  end

  assign of_valid = of_valid_q;
  assign of_pc    = pc_q;
  assign of_inst  = inst_q;
  assign of_op1   = op1_q;
  assign of_op2   = op2_q;
  assign of_immx  = immx_q;

endmodule
